// File: rtl/cska_serial_subtractor.sv
// cska_serial_subtractor
//   Block-serial borrow-skip subtractor: Diff = A - B - Bin, processed one
//   BLOCK_WIDTH slice per clock, LSB slice first. When every bit pair in a
//   slice is equal, the slice borrow-out bypasses the ripple chain and is
//   taken straight from the slice borrow-in.
//
//   Optional feature macro: CSKA_SKIP_STATS_EN (adds the skip_cnt port and
//   counter; Diff/Bout behaviour and timing are unchanged either way).
//
// Parameters
//   TOTAL_WIDTH  operand/result width (integer multiple of BLOCK_WIDTH)
//   BLOCK_WIDTH  bits processed per cycle; NBLK = TOTAL_WIDTH/BLOCK_WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands valid            in_ready   idle, able to accept
//   A, B, Bin  minuend, subtrahend, borrow-in
//   out_valid  result valid              out_ready  consumer accepts result
//   Diff       (A - B - Bin) mod 2^TOTAL_WIDTH
//   Bout       final borrow (A < B + Bin, unsigned)
//   skip_cnt   slices whose borrow was skipped (CSKA_SKIP_STATS_EN only)

module cska_serial_subtractor #(
    parameter int TOTAL_WIDTH = 16,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TOTAL_WIDTH-1:0] A,
    input  logic [TOTAL_WIDTH-1:0] B,
    input  logic                   Bin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOTAL_WIDTH-1:0] Diff,
`ifdef CSKA_SKIP_STATS_EN
    output logic                   Bout,
    output logic [$clog2(TOTAL_WIDTH/BLOCK_WIDTH+1)-1:0] skip_cnt
`else
    output logic                   Bout
`endif
);

    localparam int NBLK  = TOTAL_WIDTH / BLOCK_WIDTH;
    localparam int IDXW  = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int BASEW = (TOTAL_WIDTH > 1) ? $clog2(TOTAL_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [TOTAL_WIDTH-1:0] a_q;
    logic [TOTAL_WIDTH-1:0] b_q;
    logic                   br_q;      // borrow into the current slice
    logic [IDXW-1:0]        blk_idx;
    logic                   last_blk;

    logic [BASEW-1:0]       slice_base;
    logic [BLOCK_WIDTH-1:0] slice_a;
    logic [BLOCK_WIDTH-1:0] slice_b;
    logic [BLOCK_WIDTH-1:0] slice_d;
    logic                   ripple_br;
    logic                   slice_pb;
    logic                   slice_bout;

    assign in_ready = (state == IDLE);
    assign last_blk = (blk_idx == IDXW'(NBLK - 1));

    // ------------------------------------------------------------------
    // State register and next-state decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_blk)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Slice arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        slice_base = BASEW'(blk_idx) * BASEW'(BLOCK_WIDTH);
        slice_a    = a_q[slice_base +: BLOCK_WIDTH];
        slice_b    = b_q[slice_base +: BLOCK_WIDTH];
        slice_d    = '0;
        ripple_br  = br_q;
        for (int unsigned i = 0; i < BLOCK_WIDTH; i++) begin
            slice_d[i] = slice_a[i] ^ slice_b[i] ^ ripple_br;
            ripple_br  = (~slice_a[i] & slice_b[i]) |
                         (~(slice_a[i] ^ slice_b[i]) & ripple_br);
        end
        // All bit pairs equal: the ripple just forwards the borrow-in, so the
        // bypass yields the same value with a single mux of depth.
        slice_pb   = &(~(slice_a ^ slice_b));
        slice_bout = slice_pb ? br_q : ripple_br;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            br_q      <= 1'b0;
            blk_idx   <= '0;
            Diff      <= '0;
            Bout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        br_q    <= Bin;
                        blk_idx <= '0;
                        Diff    <= '0;
                    end
                end
                RUN: begin
                    Diff[slice_base +: BLOCK_WIDTH] <= slice_d;
                    br_q <= slice_bout;
                    if (last_blk) begin
                        Bout      <= slice_bout;
                        out_valid <= 1'b1;
                    end else begin
                        blk_idx <= blk_idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CSKA_SKIP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_cnt <= '0;
        end else if (state == IDLE && in_valid) begin
            skip_cnt <= '0;
        end else if (state == RUN && slice_pb) begin
            skip_cnt <= skip_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cska_serial_subtractor.sv
// tb_cska_serial_subtractor
//   Self-checking bench for cska_serial_subtractor. A behavioural model
//   (plain integer subtraction plus a handshake phase tracker) is checked
//   against the DUT on every falling edge; directed operations pin the model
//   with hand-computed literals, then randomized traffic with random
//   backpressure runs 1000 operations.
//   BLOCK_WIDTH may be overridden on this module; CSKA_SKIP_STATS_EN is honoured.

module tb_cska_serial_subtractor #(
    parameter int BLOCK_WIDTH = 4
);

    localparam int TW   = 16;
    localparam int NBLK = TW / BLOCK_WIDTH;
    localparam int SKW  = $clog2(NBLK + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] A;
    logic [TW-1:0] B;
    logic          Bin;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] Diff;
    logic          Bout;
`ifdef CSKA_SKIP_STATS_EN
    logic [SKW-1:0] skip_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    cska_serial_subtractor #(
        .TOTAL_WIDTH (TW),
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
`ifdef CSKA_SKIP_STATS_EN
        .Bout      (Bout),
        .skip_cnt  (skip_cnt)
`else
        .Bout      (Bout)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int            m_phase = 0;   // 0 idle, 1 computing, 2 result held
    int            m_left  = 0;
    logic [TW-1:0] m_diff;
    logic          m_bout;
    int            m_skip;

    task automatic model_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic bi);
        logic [TW:0] full;
        logic [TW-1:0] av, bv;
        full   = {1'b0, a} - {1'b0, b} - (TW+1)'(bi);
        m_diff = full[TW-1:0];
        m_bout = full[TW];
        m_skip = 0;
        av = a;
        bv = b;
        for (int k = 0; k < NBLK; k++) begin
            if (av[k*BLOCK_WIDTH +: BLOCK_WIDTH] == bv[k*BLOCK_WIDTH +: BLOCK_WIDTH])
                m_skip++;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            m_phase = 0;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_diff", Diff, 0);
            chk("rst_bout", Bout, 0);
`ifdef CSKA_SKIP_STATS_EN
            chk("rst_skip_cnt", skip_cnt, 0);
`endif
        end else begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("out_valid", out_valid, m_phase == 2);
            if (m_phase == 2) begin
                chk("diff", Diff, m_diff);
                chk("bout", Bout, m_bout);
`ifdef CSKA_SKIP_STATS_EN
                chk("skip_cnt", skip_cnt, m_skip);
`endif
            end
            case (m_phase)
                0: if (in_valid) begin
                    model_op(A, B, Bin);
                    m_phase = 1;
                    m_left  = NBLK;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) begin
                    m_phase = 0;
                    n_done++;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Directed operation with literal expectations and optional stall
    // ------------------------------------------------------------------
    task automatic do_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic bi,
                         input logic [TW-1:0] ed, input logic eb, input int hold);
        int n   = 0;
        int lat = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_wait", in_ready, 1);
        A = a; B = b; Bin = bi; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, NBLK);
        chk("lit_diff", Diff, ed);
        chk("lit_bout", Bout, eb);
        for (int i = 0; i < hold; i++) begin
            A = TW'($urandom); B = TW'($urandom); Bin = 1'($urandom);
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            chk("bp_diff", Diff, ed);
            chk("bp_bout", Bout, eb);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_miss++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int cyc;
        logic [TW-1:0] r;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Bin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        do_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 0);
        do_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0);
        do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0, 5);

        // Reset two slices into an operation
        A = 16'h7777; B = 16'h1111; Bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("async_rst_diff", Diff, 0);
        chk("async_rst_bout", Bout, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 0);

        // Randomized traffic with random backpressure
        start = n_done;
        cyc   = 0;
        while (n_done - start < 1000 && cyc < 60000) begin
            B = TW'($urandom);
            r = TW'($urandom);
            A = ($urandom_range(0, 2) == 0) ? ((B & 16'hF0F0) | (r & 16'h0F0F)) : r;
            Bin       = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("random_ops_completed", (n_done - start >= 1000), 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
